// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial complement engine.
// Holds the FSM state encoding and the operand mode select values.
// Imported by the top and by the bit cell.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/serial_complementer_bit_cell.sv
// One bit slice of the ones/twos complement rule, purely combinational.
// Twos mode copies bits up to and including the first one, then inverts.
// Time-multiplexed by the top across all bit positions.
module complement_bit_cell
  import cmp_pkg::*;
(
  input  logic a_bit,
  input  logic mode,
  input  logic seen_one,
  output logic y_bit,
  output logic seen_one_next
);

  // Invert always in ones mode; in twos mode invert only past the first one.
  always_comb begin
    y_bit         = ~a_bit;
    seen_one_next = seen_one | a_bit;
    if (mode == MODE_TWOS && !seen_one) begin
      y_bit = a_bit;
    end
  end

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial ones/twos complement engine, LSB first, one bit per clock.
// Result valid WIDTH cycles after accept; one operand per WIDTH+2 cycles.
// in_ready only in IDLE; result held in DONE until out_ready.
module serial_complementer
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic             mode_q;
  logic             seen_one_q;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             a_bit;
  logic             y_bit_d;
  logic             seen_one_d;
  logic             ovf_d;

  assign a_bit = a_q[cnt_q];

  complement_bit_cell u_cell (
    .a_bit         (a_bit),
    .mode          (mode_q),
    .seen_one      (seen_one_q),
    .y_bit         (y_bit_d),
    .seen_one_next (seen_one_d)
  );

  // Most negative operand in twos mode complements to itself.
  always_comb begin
    ovf_d = (mode_q == MODE_TWOS) && a_q[WIDTH-1] && (a_q[WIDTH-2:0] == '0);
  end

  // Control FSM plus the serial datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      mode_q      <= MODE_ONES;
      seen_one_q  <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            mode_q     <= mode;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            y_q        <= '0;
            ovf_q      <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          y_q[cnt_q] <= y_bit_d;
          seen_one_q <= seen_one_d;
          if (cnt_q == CNT_LAST) begin
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule
